// File: rtl/uart_ram_loader_pkg.sv
// Shared encodings and constants for the UART-to-RAM loader and its serial receiver.
package uart_ram_loader_pkg;

  // 100 MHz system clock, 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    LD_WAIT_HI = 2'd0,
    LD_WAIT_LO = 2'd1,
    LD_WRITE   = 2'd2,
    LD_DONE    = 2'd3
  } loader_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART deserialiser: 2-flop input synchroniser, mid-bit sampling, framing check.
module uart_rx
  import uart_ram_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      rx,
  output logic [7:0] dataByte,
  output logic      byteValid,
  output logic      framingErr,
  output rx_state_e rxState
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q;
  logic             rx_s;
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       byte_q;
  logic             valid_q;
  logic             ferr_q;

  // Flops reset to the idle line level so release cannot look like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

  // byteValid/framingErr are single-cycle strobes with no back-pressure: the
  // consumer must take dataByte in the same cycle byteValid is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!rx_s) state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_q <= RX_STOP;
            else                   bit_idx_q <= bit_idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (rx_s) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign dataByte   = byte_q;
  assign byteValid  = valid_q;
  assign framingErr = ferr_q;
  assign rxState    = state_q;

endmodule

// File: rtl/uart_ram_loader.sv
// Assembles UART bytes into big-endian 16-bit words and writes WORD_COUNT of them to RAM.
module uart_ram_loader
  import uart_ram_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_WIDTH   = 8,
  parameter int WORD_COUNT   = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  output logic [15:0]           ramDataOut,
  output logic                  ramWriteEnable,
  output logic                  UART2RAMCompleted,
  output logic                  framingError,
  output rx_state_e             dbgRxState,
  output loader_state_e         dbgLoaderState
);

  // WORD_COUNT must lie in 1..2**ADDR_WIDTH so the last address is representable.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_COUNT - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  loader_state_e         ld_state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           data_q;
  logic                  we_q;
  logic                  done_q;
  logic                  ferr_q;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .dataByte  (rx_byte),
    .byteValid (rx_valid),
    .framingErr(rx_ferr),
    .rxState   (dbgRxState)
  );

  // A framing error only raises the sticky flag; pairing state is untouched
  // because the receiver never strobes byteValid for a bad frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_state_q <= LD_WAIT_HI;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (rx_ferr) ferr_q <= 1'b1;
      case (ld_state_q)
        LD_WAIT_HI: begin
          if (rx_valid) begin
            data_q[15:8] <= rx_byte;
            ld_state_q   <= LD_WAIT_LO;
          end
        end
        LD_WAIT_LO: begin
          if (rx_valid) begin
            data_q[7:0] <= rx_byte;
            we_q        <= 1'b1;
            ld_state_q  <= LD_WRITE;
          end
        end
        LD_WRITE: begin
          if (addr_q == LAST_ADDR) begin
            done_q     <= 1'b1;
            ld_state_q <= LD_DONE;
          end else begin
            addr_q     <= addr_q + 1'b1;
            ld_state_q <= LD_WAIT_HI;
          end
        end
        LD_DONE: ld_state_q <= LD_DONE;
        default: ld_state_q <= LD_WAIT_HI;
      endcase
    end
  end

  assign ramAddr           = addr_q;
  assign ramDataOut        = data_q;
  assign ramWriteEnable    = we_q;
  assign UART2RAMCompleted = done_q;
  assign framingError      = ferr_q;
  assign dbgLoaderState    = ld_state_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Scoreboard bench for uart_ram_loader: serial driver, word-level reference model, write monitor.
module tb_uart_ram_loader;
  import uart_ram_loader_pkg::*;

  localparam int CPB = 4;
  localparam int AW  = 8;
  localparam int WC  = 4;

  logic          clk;
  logic          reset_n;
  logic          rx;
  logic [AW-1:0] ramAddr;
  logic [15:0]   ramDataOut;
  logic          ramWriteEnable;
  logic          UART2RAMCompleted;
  logic          framingError;
  rx_state_e     dbgRxState;
  loader_state_e dbgLoaderState;

  uart_ram_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .WORD_COUNT  (WC)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .rx               (rx),
    .ramAddr          (ramAddr),
    .ramDataOut       (ramDataOut),
    .ramWriteEnable   (ramWriteEnable),
    .UART2RAMCompleted(UART2RAMCompleted),
    .framingError     (framingError),
    .dbgRxState       (dbgRxState),
    .dbgLoaderState   (dbgLoaderState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected write entries: {addr[7:0], data[15:0]}
  logic [23:0] exp_q[$];
  bit          m_have_hi;
  logic [7:0]  m_hi;
  int          m_words;
  bit          m_ferr;
  bit          last_pending;

  task automatic model_clear();
    m_have_hi    = 0;
    m_hi         = '0;
    m_words      = 0;
    m_ferr       = 0;
    last_pending = 0;
    exp_q.delete();
  endtask

  task automatic model_good_byte(input logic [7:0] d);
    if (m_words >= WC) return;
    if (!m_have_hi) begin
      m_hi      = d;
      m_have_hi = 1;
    end else begin
      exp_q.push_back({8'(m_words), m_hi, d});
      m_words++;
      m_have_hi = 0;
    end
  endtask

  function automatic int model_addr();
    return (m_words == WC) ? WC - 1 : m_words;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bit_period(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop_ok, input int gap);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(d[i]);
    if (stop_ok) model_good_byte(d);
    else         m_ferr = 1;
    bit_period(stop_ok);
    rx = 1'b1;
    // Give the receiver a clean idle line after a bad frame so it resynchronises.
    if (!stop_ok) repeat (2 * CPB) @(negedge clk);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    rx      = 1'b1;
    #1;
    check("reset_addr", 32'(ramAddr), 0);
    check("reset_data", 32'(ramDataOut), 0);
    check("reset_we", 32'(ramWriteEnable), 0);
    check("reset_done", 32'(UART2RAMCompleted), 0);
    check("reset_ferr", 32'(framingError), 0);
    repeat (2) @(negedge clk);
    model_clear();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain_and_check(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 0);
    repeat (4 * CPB) @(negedge clk);
    check({tag, "_done"}, 32'(UART2RAMCompleted), 32'(m_words == WC));
    check({tag, "_ferr"}, 32'(framingError), 32'(m_ferr));
    check({tag, "_addr"}, 32'(ramAddr), 32'(model_addr()));
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [23:0] e;
    bit prev_we;
    prev_we = 0;
    forever begin
      @(negedge clk);
      if (reset_n && ramWriteEnable) begin
        check("we_single_cycle", 32'(prev_we), 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write (t=%0t)",
                   ramAddr, ramDataOut, $time);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(ramAddr), 32'(e[23:16]));
          check("write_data", 32'(ramDataOut), 32'(e[15:0]));
          check("done_during_write", 32'(UART2RAMCompleted), 0);
          if (e[23:16] == 8'(WC - 1)) last_pending = 1;
        end
      end else if (reset_n && last_pending) begin
        check("done_after_last", 32'(UART2RAMCompleted), 1);
        last_pending = 0;
      end
      prev_we = reset_n && ramWriteEnable;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rx      = 1'b1;
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    do_reset();

    // Single word
    send_byte(8'h12, 1, 0);
    send_byte(8'h34, 1, 0);
    drain_and_check("one_word");

    // Full load, back-to-back frames, then an ignored extra byte
    do_reset();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1, 0);
    send_byte(8'hFF, 1, 0);
    drain_and_check("full_load");

    // Framing error does not consume a half-word
    do_reset();
    send_byte(8'hAA, 0, 0);
    send_byte(8'h55, 1, 0);
    send_byte(8'h66, 1, 0);
    drain_and_check("framing");

    // Short glitch while idle is rejected
    do_reset();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    drain_and_check("glitch");
    send_byte(8'h9A, 1, 0);
    send_byte(8'hBC, 1, 0);
    drain_and_check("after_glitch");

    // Reset mid-word and mid-byte discards partial data
    do_reset();
    send_byte(8'h12, 1, 0);
    bit_period(1'b0);
    for (int i = 0; i < 4; i++) bit_period(1'b1);
    do_reset();
    send_byte(8'hAB, 1, 0);
    send_byte(8'hCD, 1, 0);
    drain_and_check("reset_mid");

    // Randomised streams with occasional bad frames and random gaps
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 11; i++) begin
        send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0,
                  $urandom_range(0, 2));
      end
      drain_and_check("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
